core_ifetch: RTL and testbench



---
 rtl/core_ifetch_pkg.sv | 22 ++
 rtl/core_sync_fifo.sv | 63 ++++++
 rtl/core_ifetch.sv | 154 +++++++++++++++
 tb/tb_core_ifetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ifetch_pkg.sv
// rtl/core_ifetch_pkg.sv - shared constants, fetch entry type and PC helpers for the fetch front end
package core_ifetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR  = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR  = 2'b11;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One prefetch buffer entry as seen by decode
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            err;
  } fetch_entry_t;

  // Instructions are word aligned; low address bits are ignored
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_sync_fifo.sv
// rtl/core_sync_fifo.sv - synchronous FIFO with flush, used for prefetch data and in-order PC tags
module core_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Caller guarantees no push into a full FIFO unless it pops in the same cycle
  assign w_pop   = i_pop & (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Storage, pointers and occupancy; flush empties without touching storage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/core_ifetch.sv
// rtl/core_ifetch.sv - AXI4-Lite instruction fetch front end with prefetch buffer and redirect flush
module core_ifetch
  import core_ifetch_pkg::*;
#(
  parameter int          AXI_AWIDTH      = 32,
  parameter int          AXI_DWIDTH      = 32,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [AXI_AWIDTH-1:0] IMEM_AXI_ARADDR,
  output logic                  IMEM_AXI_ARVALID,
  input  logic                  IMEM_AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0] IMEM_AXI_RDATA,
  input  logic [1:0]            IMEM_AXI_RRESP,
  input  logic                  IMEM_AXI_RVALID,
  output logic                  IMEM_AXI_RREADY,
  input  logic                  REDIR_VALID,
  input  logic [31:0]           REDIR_PC,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic [31:0]           INSTR_DATA,
  output logic [31:0]           INSTR_PC,
  output logic                  INSTR_ERR
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                  r_arvalid;
  logic [AXI_AWIDTH-1:0] r_araddr;
  logic                  r_rready;
  logic [XLEN-1:0]       r_fetch_pc;
  logic [OW-1:0]         r_outstanding;
  logic [OW-1:0]         r_drop_cnt;

  logic                  w_ar_hs;
  logic                  w_rbeat;
  logic                  w_keep_beat;
  logic                  w_drop_beat;
  logic                  w_pop;
  logic                  w_issue;
  logic [31:0]           w_out_eff;
  logic [31:0]           w_tag_eff;
  logic [31:0]           w_cnt_eff;

  logic                  w_pf_push;
  logic                  w_pf_full;
  logic                  w_pf_empty;
  logic [CW-1:0]         w_pf_count;
  fetch_entry_t          w_pf_wdata;
  fetch_entry_t          w_pf_rdata;

  logic                  w_tag_push;
  logic                  w_tag_full;
  logic                  w_tag_empty;
  logic [OW-1:0]         w_tag_count;
  logic [XLEN-1:0]       w_tag_pc;

  assign w_ar_hs     = r_arvalid & IMEM_AXI_ARREADY;
  assign w_rbeat     = IMEM_AXI_RVALID & r_rready;
  assign w_drop_beat = w_rbeat & (r_drop_cnt != '0);
  // A beat landing in the redirect cycle belongs to the old stream and is discarded
  assign w_keep_beat = w_rbeat & (r_drop_cnt == '0) & ~REDIR_VALID & ~w_tag_empty;
  assign w_pop       = ~w_pf_empty & INSTR_READY;

  assign w_pf_wdata = '{pc: w_tag_pc, data: IMEM_AXI_RDATA, err: |IMEM_AXI_RRESP};
  assign w_pf_push  = w_keep_beat & (~w_pf_full | w_pop);
  assign w_tag_push = w_issue & (~w_tag_full | w_keep_beat);

  // Credit check on next-cycle occupancy so a completing beat frees its slot
  // immediately, which is what sustains one fetch per cycle.
  always_comb begin
    w_out_eff = 32'(r_outstanding) - 32'(w_rbeat);
    w_tag_eff = 32'(w_tag_count) - 32'(w_keep_beat);
    w_cnt_eff = 32'(w_pf_count) + 32'(w_keep_beat) - 32'(w_pop);
    w_issue   = ~REDIR_VALID
              & (~r_arvalid | w_ar_hs)
              & (r_drop_cnt == '0)
              & (w_out_eff < 32'(MAX_OUTSTANDING))
              & (w_tag_eff < 32'(MAX_OUTSTANDING))
              & ((w_out_eff + w_cnt_eff) < 32'(FIFO_DEPTH));
  end

  // AR channel, fetch address and in-flight bookkeeping
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_arvalid     <= 1'b0;
      r_araddr      <= RESET_PC[AXI_AWIDTH-1:0];
      r_rready      <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_rready <= 1'b1;
      if (w_issue) begin
        r_arvalid <= 1'b1;
        r_araddr  <= r_fetch_pc[AXI_AWIDTH-1:0];
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
      // r_fetch_pc is the address of the next AR to raise, so a pending AR
      // keeps its own ARADDR while a redirect retargets future fetches.
      if (REDIR_VALID) r_fetch_pc <= align_pc(REDIR_PC);
      else if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outstanding <= r_outstanding + OW'(w_issue) - OW'(w_rbeat);
      if (REDIR_VALID) r_drop_cnt <= r_outstanding - OW'(w_rbeat);
      else if (w_drop_beat) r_drop_cnt <= r_drop_cnt - OW'(1);
    end
  end

  core_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_pf_push),
    .i_wdata (w_pf_wdata),
    .i_pop   (w_pop),
    .i_flush (REDIR_VALID),
    .o_rdata (w_pf_rdata),
    .o_full  (w_pf_full),
    .o_empty (w_pf_empty),
    .o_count (w_pf_count)
  );

  core_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_queue (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_tag_push),
    .i_wdata (r_fetch_pc),
    .i_pop   (w_keep_beat),
    .i_flush (REDIR_VALID),
    .o_rdata (w_tag_pc),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  assign IMEM_AXI_ARADDR  = r_araddr;
  assign IMEM_AXI_ARVALID = r_arvalid;
  assign IMEM_AXI_RREADY  = r_rready;
  assign INSTR_VALID      = ~w_pf_empty;
  assign INSTR_DATA       = w_pf_rdata.data;
  assign INSTR_PC         = w_pf_rdata.pc;
  assign INSTR_ERR        = w_pf_rdata.err;

endmodule

// File: tb/tb_core_ifetch.sv
// tb/tb_core_ifetch.sv - directed self-checking bench for core_ifetch with an in-order AXI4-Lite slave
module tb_core_ifetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY = 1'b1;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic        REDIR_VALID = 1'b0;
  logic [31:0] REDIR_PC = '0;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic [31:0] INSTR_DATA;
  logic [31:0] INSTR_PC;
  logic        INSTR_ERR;

  logic        r_en = 1'b1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          ar_cnt;
  int          pop_cnt;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  logic [31:0] q_r[$];

  always #5 CLK = ~CLK;

  core_ifetch #(
    .AXI_AWIDTH      (32),
    .AXI_DWIDTH      (32),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .IMEM_AXI_ARADDR  (ARADDR),
    .IMEM_AXI_ARVALID (ARVALID),
    .IMEM_AXI_ARREADY (ARREADY),
    .IMEM_AXI_RDATA   (RDATA),
    .IMEM_AXI_RRESP   (RRESP),
    .IMEM_AXI_RVALID  (RVALID),
    .IMEM_AXI_RREADY  (RREADY),
    .REDIR_VALID      (REDIR_VALID),
    .REDIR_PC         (REDIR_PC),
    .INSTR_VALID      (INSTR_VALID),
    .INSTR_READY      (INSTR_READY),
    .INSTR_DATA       (INSTR_DATA),
    .INSTR_PC         (INSTR_PC),
    .INSTR_ERR        (INSTR_ERR)
  );

  // Zero-wait in-order slave: a beat is presented the cycle after its AR handshake
  always @(posedge CLK) begin
    logic        hs_ar;
    logic        acc;
    logic [31:0] a;
    hs_ar = ARVALID & ARREADY;
    acc   = RVALID & RREADY;
    a     = ARADDR;
    if (RST) begin
      ar_cnt  = 0;
      pop_cnt = 0;
    end else begin
      if (hs_ar) ar_cnt++;
      if (INSTR_VALID & INSTR_READY) pop_cnt++;
    end
    #1;
    if (RST) q_r.delete();
    else begin
      if (acc && q_r.size() > 0) void'(q_r.pop_front());
      if (hs_ar) q_r.push_back(a);
    end
    if (r_en && q_r.size() > 0 && !RST) begin
      RVALID = 1'b1;
      RDATA  = 32'h1300_0000 + q_r[0];
      RRESP  = (q_r[0] == err_addr) ? 2'b10 : 2'b00;
    end else begin
      RVALID = 1'b0;
      RDATA  = '0;
      RRESP  = '0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 32'(ARVALID), 32'h0);
    chk({tag, "_araddr"}, ARADDR, 32'h0);
    chk({tag, "_rready"}, 32'(RREADY), 32'h0);
    chk({tag, "_ivalid"}, 32'(INSTR_VALID), 32'h0);
    chk({tag, "_idata"}, INSTR_DATA, 32'h0);
    chk({tag, "_ipc"}, INSTR_PC, 32'h0);
    chk({tag, "_ierr"}, 32'(INSTR_ERR), 32'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_reset_outputs("reset");

    // Sustained stream with an error response at 0x8
    err_addr    = 32'h8;
    INSTR_READY = 1'b1;
    RST         = 1'b0;
    tick();
    chk("first_arvalid", 32'(ARVALID), 32'h1);
    chk("first_araddr", ARADDR, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", 32'(INSTR_VALID), 32'h1);
      chk("stream_pc", INSTR_PC, 32'(4 * i));
      chk("stream_data", INSTR_DATA, 32'h1300_0000 + 32'(4 * i));
      chk("stream_err", 32'(INSTR_ERR), (i == 2) ? 32'h1 : 32'h0);
      tick();
    end

    // One-cycle reset in the middle of the burst
    RST = 1'b1;
    tick();
    chk_reset_outputs("midreset");
    RST      = 1'b0;
    err_addr = 32'hFFFF_FFFF;
    tick();
    chk("restart_arvalid", 32'(ARVALID), 32'h1);
    chk("restart_araddr", ARADDR, 32'h0);
    tick();
    tick();
    chk("restart_pc", INSTR_PC, 32'h0);
    chk("restart_valid", 32'(INSTR_VALID), 32'h1);

    // Decode stall fills exactly FIFO_DEPTH entries
    INSTR_READY = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    chk("stall_ar_cnt", 32'(ar_cnt), 32'd4);
    chk("stall_arvalid", 32'(ARVALID), 32'h0);
    chk("stall_hold_pc", INSTR_PC, 32'h0);
    INSTR_READY = 1'b1;
    chk("release_pc0", INSTR_PC, 32'h0);
    tick();
    chk("release_pc4", INSTR_PC, 32'h4);
    chk("resume_arvalid", 32'(ARVALID), 32'h1);
    chk("resume_araddr", ARADDR, 32'h10);
    tick();
    chk("release_pc8", INSTR_PC, 32'h8);
    tick();
    chk("release_pcc", INSTR_PC, 32'hC);
    tick();
    chk("release_pc10", INSTR_PC, 32'h10);
    chk("release_valid", 32'(INSTR_VALID), 32'h1);

    // ARREADY held low with AR at 0x8 pending
    do_reset();
    tick();
    tick();
    tick();
    ARREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arhold_valid", 32'(ARVALID), 32'h1);
      chk("arhold_addr", ARADDR, 32'h8);
    end
    chk("arhold_cnt", 32'(ar_cnt), 32'd2);
    ARREADY = 1'b1;
    tick();
    chk("arhold_next_addr", ARADDR, 32'hC);

    // Redirect with two responses held in flight
    r_en = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    chk("inflight_arvalid", 32'(ARVALID), 32'h0);
    REDIR_VALID = 1'b1;
    REDIR_PC    = 32'h0000_0102;
    r_en        = 1'b1;
    tick();
    REDIR_VALID = 1'b0;
    chk("redir1_ivalid", 32'(INSTR_VALID), 32'h0);
    chk("redir1_drop", 32'(dut.r_drop_cnt), 32'd2);
    tick();
    tick();
    chk("redir1_drain_arvalid", 32'(ARVALID), 32'h0);
    tick();
    chk("redir1_arvalid", 32'(ARVALID), 32'h1);
    chk("redir1_araddr", ARADDR, 32'h100);
    tick();
    tick();
    chk("redir1_valid", 32'(INSTR_VALID), 32'h1);
    chk("redir1_pc", INSTR_PC, 32'h100);
    chk("redir1_data", INSTR_DATA, 32'h1300_0100);

    // Redirect coinciding with an R beat and a decode pop
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    chk("redir2_pre_pc", INSTR_PC, 32'h4);
    chk("redir2_pre_rvalid", 32'(RVALID), 32'h1);
    REDIR_VALID = 1'b1;
    REDIR_PC    = 32'h0000_0203;
    tick();
    REDIR_VALID = 1'b0;
    chk("redir2_ivalid", 32'(INSTR_VALID), 32'h0);
    chk("redir2_drop", 32'(dut.r_drop_cnt), 32'd1);
    chk("redir2_pops", 32'(pop_cnt), 32'd2);
    chk("redir2_arvalid", 32'(ARVALID), 32'h0);
    tick();
    chk("redir2_drain_arvalid", 32'(ARVALID), 32'h0);
    tick();
    chk("redir2_araddr", ARADDR, 32'h200);
    chk("redir2_new_arvalid", 32'(ARVALID), 32'h1);
    tick();
    tick();
    chk("redir2_valid", 32'(INSTR_VALID), 32'h1);
    chk("redir2_pc", INSTR_PC, 32'h200);
    chk("redir2_total_pops", 32'(pop_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
